// File: rtl/pga_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pga_ctrl_pkg
// Shared definitions for the PGA auto-ranging controller:
//   - state_t       : sequencer states (IDLE, SETTLE, MEASURE, DECIDE)
//   - *_DEF         : default widths, timing and amplitude thresholds
//   - fs_pos/fs_neg : full-scale codes of a signed two's-complement word
// No ports (package).
// -----------------------------------------------------------------------------
package pga_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DECIDE  = 2'd3
  } state_t;

  localparam int ADC_W_DEF      = 12;
  localparam int GW_DEF         = 3;
  localparam int SETTLE_CYC_DEF = 64;
  localparam int WIN_LEN_DEF    = 256;
  localparam int HI_TH_DEF      = 3000;
  localparam int LO_TH_DEF      = 1200;

  // Most positive code of a w-bit signed sample (e.g. +2047 for w=12).
  function automatic int fs_pos(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Most negative code of a w-bit signed sample (e.g. -2048 for w=12).
  function automatic int fs_neg(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/pga_minmax_tracker.sv
// -----------------------------------------------------------------------------
// pga_minmax_tracker
// Windowed signed min/max tracker. Accepts up to WIN_LEN qualified samples
// after a clear and raises done once the window is full; further samples are
// ignored until the next clear.
// Ports:
//   clk    in   1      system clock, rising edge
//   rst_n  in   1      asynchronous active-low reset (sample counter only)
//   clr    in   1      restart the window (min/max/count)
//   valid  in   1      data qualifier
//   data   in   ADC_W  signed sample
//   min    out  ADC_W  smallest sample in the current window
//   max    out  ADC_W  largest sample in the current window
//   done   out  1      WIN_LEN samples have been taken
// -----------------------------------------------------------------------------
module pga_minmax_tracker
  import pga_ctrl_pkg::*;
#(
  parameter int ADC_W   = ADC_W_DEF,
  parameter int WIN_LEN = WIN_LEN_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    valid,
  input  logic signed [ADC_W-1:0] data,
  output logic signed [ADC_W-1:0] min,
  output logic signed [ADC_W-1:0] max,
  output logic                    done
);

  localparam int CNT_W = $clog2(WIN_LEN + 1);
  localparam logic signed [ADC_W-1:0] FS_POS = ADC_W'(fs_pos(ADC_W));
  localparam logic signed [ADC_W-1:0] FS_NEG = ADC_W'(fs_neg(ADC_W));

  logic [CNT_W-1:0] cnt;
  logic             take;

  assign done = (cnt == CNT_W'(WIN_LEN));
  assign take = valid && !done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (take) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Extremes start inverted so the first accepted sample overwrites both.
  always_ff @(posedge clk) begin
    if (clr) begin
      min <= FS_POS;
      max <= FS_NEG;
    end else if (take) begin
      if (data < min) min <= data;
      if (data > max) max <= data;
    end
  end

endmodule

// File: rtl/pga_autorange_ctrl.sv
// -----------------------------------------------------------------------------
// pga_autorange_ctrl
// Auto-ranging sequencer for a switched-feedback op-amp gain stage. After
// every gain change (and after enable) it waits SETTLE_CYC clocks, measures
// the ADC peak-to-peak over WIN_LEN valid samples and steps the gain one code
// down (pp > HI_TH) or up (pp < LO_TH) until the amplitude is in band, then
// reports it continuously, one window at a time.
// Ports:
//   clk        in   1        system clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   enable     in   1        run auto-ranging; low returns to IDLE
//   adc_valid  in   1        adc_data qualifier
//   adc_data   in   ADC_W    signed two's-complement sample
//   gain_code  out  GW       feedback-ladder tap select
//   gain_wr    out  1        one-cycle strobe when gain_code changes
//   amp_pp     out  ADC_W+1  last reported peak-to-peak, unsigned
//   amp_valid  out  1        one-cycle strobe on amp_pp update
//   locked     out  1        last window was accepted without a gain step
//   overload   out  1        sticky: full-scale sample seen at gain code 0
//   busy       out  1        sequencer not idle
// -----------------------------------------------------------------------------
module pga_autorange_ctrl
  import pga_ctrl_pkg::*;
#(
  parameter int ADC_W      = ADC_W_DEF,
  parameter int GW         = GW_DEF,
  parameter int GAIN_INIT  = 0,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int WIN_LEN    = WIN_LEN_DEF,
  parameter int HI_TH      = HI_TH_DEF,
  parameter int LO_TH      = LO_TH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    adc_valid,
  input  logic signed [ADC_W-1:0] adc_data,
  output logic [GW-1:0]           gain_code,
  output logic                    gain_wr,
  output logic [ADC_W:0]          amp_pp,
  output logic                    amp_valid,
  output logic                    locked,
  output logic                    overload,
  output logic                    busy
);

  localparam int SC_W = $clog2(SETTLE_CYC + 1);
  localparam logic [GW-1:0] GAIN_MAX  = GW'((1 << GW) - 1);
  localparam logic [GW-1:0] GAIN_RST  = GW'(GAIN_INIT);
  localparam logic [ADC_W:0] HI_LIM   = (ADC_W + 1)'(HI_TH);
  localparam logic [ADC_W:0] LO_LIM   = (ADC_W + 1)'(LO_TH);
  localparam logic signed [ADC_W-1:0] FS_POS = ADC_W'(fs_pos(ADC_W));
  localparam logic signed [ADC_W-1:0] FS_NEG = ADC_W'(fs_neg(ADC_W));

  state_t                  state;
  logic [SC_W-1:0]         settle_cnt;
  logic                    no_inc;

  logic                    trk_clr;
  logic                    trk_valid;
  logic signed [ADC_W-1:0] trk_min;
  logic signed [ADC_W-1:0] trk_max;
  logic                    trk_done;

  logic signed [ADC_W:0]   max_x;
  logic signed [ADC_W:0]   min_x;
  logic signed [ADC_W:0]   pp_s;
  logic [ADC_W:0]          pp;
  logic                    fs_hit;
  logic                    pp_high;
  logic                    pp_low;
  logic                    pp_in_band;

  // The window restarts whenever we are not actively measuring, so entry
  // into MEASURE (from SETTLE or from a locked DECIDE) always sees a clean
  // tracker; samples are accepted only while measuring.
  assign trk_clr   = (state != ST_MEASURE);
  assign trk_valid = adc_valid && (state == ST_MEASURE);

  pga_minmax_tracker #(
    .ADC_W   (ADC_W),
    .WIN_LEN (WIN_LEN)
  ) u_tracker (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (trk_clr),
    .valid (trk_valid),
    .data  (adc_data),
    .min   (trk_min),
    .max   (trk_max),
    .done  (trk_done)
  );

  // One extra bit so max - min cannot overflow (worst case +FS - -FS).
  assign max_x      = {trk_max[ADC_W-1], trk_max};
  assign min_x      = {trk_min[ADC_W-1], trk_min};
  assign pp_s       = max_x - min_x;
  assign pp         = pp_s;
  assign pp_high    = (pp > HI_LIM);
  assign pp_low     = (pp < LO_LIM);
  assign pp_in_band = !pp_high && !pp_low;

  assign fs_hit = adc_valid && ((adc_data == FS_POS) || (adc_data == FS_NEG));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      no_inc     <= 1'b0;
      gain_code  <= GAIN_RST;
      gain_wr    <= 1'b0;
      amp_pp     <= '0;
      amp_valid  <= 1'b0;
      locked     <= 1'b0;
      overload   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      gain_wr   <= 1'b0;
      amp_valid <= 1'b0;

      if (!enable) begin
        // gain_code and amp_pp intentionally keep their values across a stop.
        state    <= ST_IDLE;
        locked   <= 1'b0;
        overload <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
            busy       <= 1'b1;
          end

          ST_SETTLE: begin
            if (settle_cnt == SC_W'(SETTLE_CYC - 1)) begin
              state <= ST_MEASURE;
            end else begin
              settle_cnt <= settle_cnt + SC_W'(1);
            end
          end

          ST_MEASURE: begin
            if (trk_done) begin
              state <= ST_DECIDE;
            end else if (fs_hit) begin
              if (gain_code != '0) begin
                // Clipping makes the window meaningless: back off at once.
                gain_code  <= gain_code - GW'(1);
                gain_wr    <= 1'b1;
                locked     <= 1'b0;
                no_inc     <= 1'b1;
                settle_cnt <= '0;
                state      <= ST_SETTLE;
              end else begin
                // Nothing lower to go to: flag it and keep measuring.
                overload <= 1'b1;
              end
            end
          end

          ST_DECIDE: begin
            if (pp_high && (gain_code != '0)) begin
              gain_code  <= gain_code - GW'(1);
              gain_wr    <= 1'b1;
              locked     <= 1'b0;
              no_inc     <= 1'b1;
              settle_cnt <= '0;
              state      <= ST_SETTLE;
            end else if (pp_low && (gain_code != GAIN_MAX) && !no_inc) begin
              gain_code  <= gain_code + GW'(1);
              gain_wr    <= 1'b1;
              locked     <= 1'b0;
              settle_cnt <= '0;
              state      <= ST_SETTLE;
            end else begin
              // In band, pinned at a rail, or an increment held off after a
              // recent decrement: report this window and keep measuring.
              amp_pp    <= pp;
              amp_valid <= 1'b1;
              locked    <= 1'b1;
              if (pp_in_band) no_inc <= 1'b0;
              state     <= ST_MEASURE;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pga_autorange_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pga_autorange_ctrl
// Directed scenario sequence with randomized sample content and valid gaps.
// The ADC input comes from a simple plant: a source amplitude scaled by
// 2**gain_code and clipped to the ADC range. Expected outcomes of each window
// are predicted per window from the ranging rules.
// -----------------------------------------------------------------------------
module tb_pga_autorange_ctrl;

  localparam int ADC_W   = 12;
  localparam int GW      = 3;
  localparam int GINIT   = 3;
  localparam int SETTLE  = 64;
  localparam int WIN     = 256;
  localparam int HI      = 3000;
  localparam int LO      = 1200;
  localparam int LAT     = SETTLE + WIN + 2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    enable = 1'b0;
  logic                    adc_valid = 1'b0;
  logic signed [ADC_W-1:0] adc_data = '0;
  logic [GW-1:0]           gain_code;
  logic                    gain_wr;
  logic [ADC_W:0]          amp_pp;
  logic                    amp_valid;
  logic                    locked;
  logic                    overload;
  logic                    busy;

  always #5 clk = ~clk;

  pga_autorange_ctrl #(
    .ADC_W      (ADC_W),
    .GW         (GW),
    .GAIN_INIT  (GINIT),
    .SETTLE_CYC (SETTLE),
    .WIN_LEN    (WIN),
    .HI_TH      (HI),
    .LO_TH      (LO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .adc_valid (adc_valid),
    .adc_data  (adc_data),
    .gain_code (gain_code),
    .gain_wr   (gain_wr),
    .amp_pp    (amp_pp),
    .amp_valid (amp_valid),
    .locked    (locked),
    .overload  (overload),
    .busy      (busy)
  );

  int vectors = 0;
  int miscompares = 0;
  int wr_count = 0;
  int src = 0;
  int gen_idx = 0;
  bit cont = 1'b1;
  bit inject = 1'b0;
  int gain_m = GINIT;
  int noinc_m = 0;
  int ovl_m = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Plant peaks for source amplitude s at gain g, clipped to the ADC range.
  function automatic int peak_hi(input int s, input int g);
    int p = s << g;
    int h = p - p / 2;
    return (h > 2047) ? 2047 : h;
  endfunction

  function automatic int peak_lo(input int s, input int g);
    int l = -((s << g) / 2);
    return (l < -2048) ? -2048 : l;
  endfunction

  task automatic drive();
    int hi, lo, v;
    hi = peak_hi(src, int'(gain_code));
    lo = peak_lo(src, int'(gain_code));
    if (inject) begin
      adc_valid = 1'b1;
      adc_data  = 12'sd2047;
      inject    = 1'b0;
      return;
    end
    adc_valid = cont ? 1'b1 : ($urandom_range(0, 3) != 0);
    if (adc_valid) begin
      case (gen_idx % 4)
        0:       v = hi;
        2:       v = lo;
        default: v = lo + int'($urandom_range(0, hi - lo));
      endcase
      adc_data = 12'(v);
      gen_idx++;
    end else begin
      adc_data = 12'($urandom);
    end
  endtask

  task automatic cyc();
    drive();
    @(posedge clk);
    #1;
    if (gain_wr) wr_count++;
  endtask

  // kind: 0 = timed out, 1 = gain step, 2 = amplitude report
  task automatic wait_evt(output int kind, output int lat, input int budget);
    kind = 0;
    lat  = 0;
    while (kind == 0 && lat < budget) begin
      cyc();
      lat++;
      if (gain_wr) kind = 1;
      else if (amp_valid) kind = 2;
    end
  endtask

  // Predict what the next completed (or aborted) window does, then observe it.
  task automatic expect_next(input int s, output bit rep, output int lat);
    int g, hi, lo, pp, ek, eg, kind;
    bit fs;
    g  = gain_m;
    hi = peak_hi(s, g);
    lo = peak_lo(s, g);
    fs = (hi == 2047) || (lo == -2048);
    pp = hi - lo;
    eg = g;
    if (fs && g > 0) begin
      ek = 1; eg = g - 1; noinc_m = 1;
    end else begin
      if (fs) ovl_m = 1;
      if (pp > HI && g > 0) begin
        ek = 1; eg = g - 1; noinc_m = 1;
      end else if (pp < LO && g < (1 << GW) - 1 && noinc_m == 0) begin
        ek = 1; eg = g + 1;
      end else begin
        ek = 2;
        if (pp >= LO && pp <= HI) noinc_m = 0;
      end
    end
    wait_evt(kind, lat, 4000);
    chk("event_kind", kind, ek);
    chk("gain_code", int'(gain_code), eg);
    chk("locked", int'(locked), (ek == 2) ? 1 : 0);
    chk("overload", int'(overload), ovl_m);
    if (ek == 2) chk("amp_pp", int'(amp_pp), pp);
    gain_m = eg;
    rep    = (ek == 2);
  endtask

  task automatic run_until_report(input int s, output int lat);
    bit rep;
    rep = 1'b0;
    for (int i = 0; i < 8 && !rep; i++) expect_next(s, rep, lat);
    chk("reached_report", int'(rep), 1);
  endtask

  initial begin
    int lat, w0;
    bit rep;

    // Reset state
    repeat (3) cyc();
    chk("rst_gain_code", int'(gain_code), GINIT);
    chk("rst_amp_pp", int'(amp_pp), 0);
    chk("rst_gain_wr", int'(gain_wr), 0);
    chk("rst_amp_valid", int'(amp_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_overload", int'(overload), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (2) cyc();
    chk("idle_busy", int'(busy), 0);

    // In-range signal at the initial gain: first report, no gain writes
    src = 225; cont = 1'b1; enable = 1'b1;
    expect_next(src, rep, lat);
    chk("first_latency", lat - 1, LAT);
    chk("no_gain_wr", wr_count, 0);

    // Too large (4000, not clipped): one decrement, then lock at 2000
    src = 500;
    expect_next(src, rep, lat);
    expect_next(src, rep, lat);
    chk("resettle_latency", lat, LAT);
    chk("gain_after_dec", int'(gain_code), 2);

    // Clipping signal, gappy valid: aborts down to 0, then overload
    cont = 1'b0; src = 4096; w0 = wr_count;
    run_until_report(src, lat);
    chk("fs_steps", wr_count - w0, 2);
    chk("overload_set", int'(overload), 1);

    // Increment held off after the decrements, then released by an in-band window
    src = 290; w0 = wr_count;
    expect_next(src, rep, lat);
    chk("inc_suppressed", wr_count - w0, 0);
    src = 1500;
    run_until_report(src, lat);

    // Small signal at gain 0: three increments to gain 3
    src = 290; w0 = wr_count;
    run_until_report(src, lat);
    chk("inc_steps", wr_count - w0, 3);
    chk("gain_after_inc", int'(gain_code), 3);

    // Climb to gain 5, then a full-scale sample mid-window
    src = 50;
    run_until_report(src, lat);
    chk("gain_before_fs", int'(gain_code), 5);
    repeat (100) cyc();
    inject = 1'b1;
    cyc();
    chk("fs_gain_wr", int'(gain_wr), 1);
    chk("fs_gain_code", int'(gain_code), 4);
    chk("fs_locked", int'(locked), 0);
    chk("fs_busy", int'(busy), 1);
    gain_m = 4; noinc_m = 1;
    expect_next(src, rep, lat);

    // Disable mid-measurement at gain 4
    repeat (50) cyc();
    chk("pre_disable_overload", int'(overload), ovl_m);
    enable = 1'b0;
    cyc();
    ovl_m = 0;
    chk("dis_busy", int'(busy), 0);
    chk("dis_gain_code", int'(gain_code), 4);
    chk("dis_locked", int'(locked), 0);
    chk("dis_overload", int'(overload), 0);
    chk("dis_amp_pp", int'(amp_pp), 800);
    chk("dis_amp_valid", int'(amp_valid), 0);
    w0 = wr_count;
    repeat (5) cyc();
    chk("dis_quiet", wr_count - w0, 0);

    // Re-enable: full settle + window again
    src = 100; cont = 1'b1; enable = 1'b1;
    expect_next(src, rep, lat);
    chk("reenable_latency", lat - 1, LAT);

    // Asynchronous reset in the middle of SETTLE
    enable = 1'b0;
    cyc();
    enable = 1'b1;
    repeat (20) cyc();
    chk("settle_busy", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gain_code", int'(gain_code), GINIT);
    chk("arst_amp_pp", int'(amp_pp), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_locked", int'(locked), 0);
    chk("arst_overload", int'(overload), 0);
    chk("arst_gain_wr", int'(gain_wr), 0);
    chk("arst_amp_valid", int'(amp_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
